aes_ks_ctrl: RTL and testbench

//  Sequences aes_key_schedule and shares its round-key read port. Accepts a new cipher key

---
 rtl/aes_ks_ctrl_pkg.sv | 13 +
 rtl/aes_ks_ctrl_if.sv | 26 ++
 rtl/aes_ks_ctrl_rr_arbiter.sv | 25 ++
 rtl/aes_ks_ctrl.sv | 92 +++++++++
 tb/tb_aes_ks_ctrl.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_ks_ctrl_pkg.sv
// aes_ks_ctrl_pkg: key-size type, round-count helper and key-schedule controller states
//   key_size_e      : AES-128/192/256 selector shared with the key schedule
//   ks_ctrl_state_e : controller FSM states
//   KS_TIMEOUT_DEF  : default watchdog length in cycles
//   get_nr()        : number of cipher rounds for a key size
package aes_ks_ctrl_pkg;
    typedef enum logic [1:0] {KS_128, KS_192, KS_256} key_size_e;
    typedef enum logic [1:0] {KC_IDLE, KC_START, KC_WAIT, KC_READY} ks_ctrl_state_e;
    localparam int KS_TIMEOUT_DEF = 32;
    function automatic logic [3:0] get_nr(input key_size_e s);
        return s == KS_256 ? 4'd14 : s == KS_192 ? 4'd12 : 4'd10;
    endfunction
endpackage

// File: rtl/aes_ks_ctrl_if.sv
// aes_ks_ctrl_if: key-load handshake and shared round-key read bus
//   key_valid_i/key_ready_o/key_size_i/key_i : key offer and acceptance
//   lock_i                                   : datapath busy, blocks key reload
//   req_i/req_idx_i/gnt_o                    : per-requester read request, index, grant
//   rk_valid_o/rk_data_o                     : one-hot data return and round key
interface aes_ks_ctrl_if #(parameter int NUM_REQ = 2);
    import aes_ks_ctrl_pkg::*;
    logic                 key_valid_i;
    logic                 key_ready_o;
    key_size_e            key_size_i;
    logic [255:0]         key_i;
    logic                 lock_i;
    logic [NUM_REQ-1:0]   req_i;
    logic [4*NUM_REQ-1:0] req_idx_i;
    logic [NUM_REQ-1:0]   gnt_o;
    logic [NUM_REQ-1:0]   rk_valid_o;
    logic [127:0]         rk_data_o;
    modport master (
        output key_valid_i, key_size_i, key_i, lock_i, req_i, req_idx_i,
        input  key_ready_o, gnt_o, rk_valid_o, rk_data_o
    );
    modport slave (
        input  key_valid_i, key_size_i, key_i, lock_i, req_i, req_idx_i,
        output key_ready_o, gnt_o, rk_valid_o, rk_data_o
    );
endinterface

// File: rtl/aes_ks_ctrl_rr_arbiter.sv
// aes_rr_arbiter: combinational round-robin arbiter
//   req : request vector
//   ptr : highest-priority requester this cycle
//   gnt : one-hot grant (zero when no request)
//   win : index of the granted requester
module aes_rr_arbiter #(
    parameter  int N = 2,
    localparam int W = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] win
);
    // Scan from the lowest priority up so the last hit is the one nearest ptr.
    always_comb begin
        gnt = '0;
        win = '0;
        for (int k = N - 1; k >= 0; k--)
            if (1'(req >> ((int'(ptr) + k) % N))) begin
                gnt = N'(1) << ((int'(ptr) + k) % N);
                win = W'((int'(ptr) + k) % N);
            end
    end
endmodule

// File: rtl/aes_ks_ctrl.sv
// aes_ks_ctrl: sequences the AES key schedule and shares its round-key read port
//   clk, rst_n            : clock, asynchronous active-low reset
//   bus (slave)           : key-load handshake and round-robin round-key read bus
//   ks_start_o            : one-cycle schedule start pulse
//   ks_key_size_o/ks_key_o: registered key and size presented to the schedule
//   ks_done_i             : schedule done level
//   ks_rk_idx_o           : round-key index to the schedule (winner's index)
//   ks_rk_data_i          : round key returned combinationally by the schedule
//   key_rdy_o, nr_o       : expanded keys valid, rounds for the loaded key
//   err_o                 : sticky watchdog timeout or out-of-range index
module aes_ks_ctrl import aes_ks_ctrl_pkg::*; #(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = KS_TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    aes_ks_ctrl_if.slave bus,
    output logic         ks_start_o,
    output key_size_e    ks_key_size_o,
    output logic [255:0] ks_key_o,
    input  logic         ks_done_i,
    output logic [3:0]   ks_rk_idx_o,
    input  logic [127:0] ks_rk_data_i,
    output logic         key_rdy_o,
    output logic [3:0]   nr_o,
    output logic         err_o
);
    localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    ks_ctrl_state_e     state;
    logic [CW-1:0]      cnt;
    logic [PW-1:0]      ptr, win;
    logic [NUM_REQ-1:0] arb_gnt;
    logic               accept, granted, timeout, bad_idx;
    aes_rr_arbiter #(.N(NUM_REQ)) u_arb (.req(bus.req_i), .ptr, .gnt(arb_gnt), .win);
    // Held low during reset so nothing upstream sees a ready before the FSM runs.
    assign bus.key_ready_o = rst_n && (state == KC_IDLE || (state == KC_READY && !bus.lock_i));
    assign accept          = bus.key_valid_i && bus.key_ready_o;
    assign bus.gnt_o       = state == KC_READY ? arb_gnt : '0;
    assign granted         = |bus.gnt_o;
    assign ks_rk_idx_o     = granted ? 4'(bus.req_idx_i >> (4 * int'(win))) : 4'd0;
    assign bad_idx         = granted && ks_rk_idx_o > nr_o;
    assign timeout         = state == KC_WAIT && !ks_done_i && cnt == CW'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= KC_IDLE;
            cnt            <= '0;
            ptr            <= '0;
            ks_start_o     <= 1'b0;
            ks_key_size_o  <= KS_128;
            ks_key_o       <= '0;
            key_rdy_o      <= 1'b0;
            nr_o           <= '0;
            err_o          <= 1'b0;
            bus.rk_valid_o <= '0;
            bus.rk_data_o  <= '0;
        end else begin
            bus.rk_valid_o <= bus.gnt_o;
            if (granted) begin
                ptr           <= win == PW'(NUM_REQ - 1) ? '0 : win + 1'b1;
                bus.rk_data_o <= bad_idx ? '0 : ks_rk_data_i;
            end
            // A grant in the accept cycle still reports against the old key.
            err_o <= timeout || bad_idx || (err_o && !accept);
            case (state)
                KC_IDLE, KC_READY:
                    if (accept) begin
                        ks_key_o      <= bus.key_i;
                        ks_key_size_o <= bus.key_size_i;
                        nr_o          <= get_nr(bus.key_size_i);
                        key_rdy_o     <= 1'b0;
                        ks_start_o    <= 1'b1;
                        state         <= KC_START;
                    end
                KC_START: begin
                    ks_start_o <= 1'b0;
                    cnt        <= '0;
                    state      <= KC_WAIT;
                end
                KC_WAIT:
                    if (ks_done_i) begin
                        key_rdy_o <= 1'b1;
                        state     <= KC_READY;
                    end else if (timeout)
                        state <= KC_IDLE;
                    else
                        cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_ks_ctrl.sv
// tb_aes_ks_ctrl: directed self-checking bench for aes_ks_ctrl with a behavioural key schedule
module tb_aes_ks_ctrl;
    import aes_ks_ctrl_pkg::*;
    localparam int NR = 2;
    localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KFIPS = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] RK128_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] RK256_14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    localparam logic [127:0] RK256_0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RK256_1  = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] RKF_10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;

    aes_ks_ctrl_if #(.NUM_REQ(NR)) bus();
    logic         ks_start, ks_done, key_rdy, err;
    key_size_e    ks_size;
    logic [255:0] ks_key;
    logic [3:0]   ks_idx, nr;
    logic [127:0] ks_data;

    aes_ks_ctrl #(.NUM_REQ(NR), .TIMEOUT_CYC(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .ks_start_o(ks_start), .ks_key_size_o(ks_size), .ks_key_o(ks_key),
        .ks_done_i(ks_done), .ks_rk_idx_o(ks_idx), .ks_rk_data_i(ks_data),
        .key_rdy_o(key_rdy), .nr_o(nr), .err_o(err)
    );

    int checks = 0, failures = 0, starts = 0;
    logic [7:0] sbox [256];
    logic stuck;
    logic [14:0][127:0] rk;
    int lat;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_of(input logic [7:0] x);
        logic [7:0] inv;
        logic [15:0] d;
        inv = 0;
        for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        d = {inv, inv};
        return inv ^ d[14 -: 8] ^ d[13 -: 8] ^ d[12 -: 8] ^ d[11 -: 8] ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    // Entries past the last round are filled with a marker so zeroing is observable.
    function automatic logic [14:0][127:0] expand_key(input logic [255:0] k, input key_size_e s);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0] rc;
        logic [14:0][127:0] r;
        int nk, nw;
        nk = s == KS_128 ? 4 : s == KS_192 ? 6 : 8;
        nw = 4 * (nk + 7);
        rc = 8'h01;
        r = {15{ {4{32'hdeadbeef}} }};
        for (int i = 0; i < 60; i++) w[i] = 0;
        for (int i = 0; i < nw; i++)
            if (i < nk) w[i] = k[255 - 32 * i -: 32];
            else begin
                t = w[i - 1];
                if (i % nk == 0) begin
                    t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
                end else if (nk == 8 && i % nk == 4)
                    t = sub_word(t);
                w[i] = w[i - nk] ^ t;
            end
        for (int j = 0; j < 15; j++)
            if (4 * j + 3 < nw) r[j] = {w[4 * j], w[4 * j + 1], w[4 * j + 2], w[4 * j + 3]};
        return r;
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ks_done <= 0;
            lat <= 0;
        end else if (ks_start) begin
            ks_done <= 0;
            lat <= ks_size == KS_256 ? 10 : ks_size == KS_192 ? 11 : 12;
            rk <= expand_key(ks_key, ks_size);
        end else if (lat == 1) begin
            lat <= 0;
            ks_done <= !stuck;
        end else if (lat > 1)
            lat <= lat - 1;

    assign ks_data = ks_idx > 4'd14 ? '0 : rk[ks_idx];

    always @(posedge clk) if (ks_start) starts <= starts + 1;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input key_size_e s, input logic [255:0] k);
        int n = 0;
        bus.key_valid_i = 1;
        bus.key_size_i = s;
        bus.key_i = k;
        #1;
        while (!bus.key_ready_o && n < 50) begin
            tick();
            n++;
        end
        if (!bus.key_ready_o) chk("load_ready", bus.key_ready_o, 1);
        tick();
        bus.key_valid_i = 0;
    endtask

    task automatic wait_rdy(input string tag, output int n);
        n = 0;
        while (!key_rdy && n < 40) begin
            tick();
            n++;
        end
        chk(tag, key_rdy, 1);
    endtask

    task automatic read(input int r, input logic [3:0] idx, input logic [127:0] exp, input string tag);
        bus.req_i = NR'(1) << r;
        bus.req_idx_i = (4 * NR)'(idx) << (4 * r);
        #1;
        chk({tag, "_gnt"}, bus.gnt_o, NR'(1) << r);
        chk({tag, "_idx"}, ks_idx, idx);
        tick();
        bus.req_i = 0;
        chk({tag, "_valid"}, bus.rk_valid_o, NR'(1) << r);
        chk({tag, "_data"}, bus.rk_data_o, exp);
        tick();
        chk({tag, "_valid_clr"}, bus.rk_valid_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL tb_timeout checks=%0d", checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        for (int x = 0; x < 256; x++) sbox[x] = sbox_of(8'(x));
        stuck = 0;
        bus.key_valid_i = 0;
        bus.key_size_i = KS_128;
        bus.key_i = '0;
        bus.lock_i = 0;
        bus.req_i = '0;
        bus.req_idx_i = '0;
        #1;
        chk("rst_ctl", {bus.key_ready_o, ks_start, key_rdy, nr, bus.gnt_o, bus.rk_valid_o, err, ks_idx}, '0);
        chk("rst_data", bus.rk_data_o, '0);
        chk("rst_key", ks_key, '0);
        tick();
        tick();
        rst_n = 1;
        tick();
        chk("idle_ready", bus.key_ready_o, 1);

        load_key(KS_128, K128);
        chk("t1_nr", nr, 10);
        chk("t1_key", ks_key, K128);
        chk("t1_start", ks_start, 1);
        wait_rdy("t1_rdy", n);
        chk("t1_lat", n, 14);
        chk("t1_starts", starts, 1);
        read(0, 4'd10, RK128_10, "t1");

        load_key(KS_256, K256);
        chk("t2_nr", nr, 14);
        wait_rdy("t2_rdy", n);
        read(0, 4'd14, RK256_14, "t2");
        read(1, 4'd0, RK256_0, "t2b");

        bus.req_i = 2'b11;
        bus.req_idx_i = {4'd0, 4'd1};
        for (int c = 0; c < 5; c++) begin
            #1;
            if (c < 4) chk("t3_gnt", bus.gnt_o, c % 2 ? 2'b10 : 2'b01);
            if (c > 0) begin
                chk("t3_valid", bus.rk_valid_o, (c - 1) % 2 ? 2'b10 : 2'b01);
                chk("t3_data", bus.rk_data_o, c % 2 ? RK256_1 : RK256_0);
            end
            tick();
            if (c == 3) bus.req_i = 0;
        end

        bus.lock_i = 1;
        bus.key_valid_i = 1;
        bus.key_size_i = KS_128;
        bus.key_i = KFIPS;
        #1;
        chk("t4_locked_ready", bus.key_ready_o, 0);
        tick();
        tick();
        chk("t4_keep_rdy", key_rdy, 1);
        chk("t4_locked_ready2", bus.key_ready_o, 0);
        chk("t4_no_start", starts, 2);
        bus.lock_i = 0;
        bus.req_i = 2'b01;
        bus.req_idx_i = 8'h01;
        #1;
        chk("t4_ready", bus.key_ready_o, 1);
        chk("t4_gnt_acc", bus.gnt_o, 2'b01);
        tick();
        bus.key_valid_i = 0;
        chk("t4_rdy_drop", key_rdy, 0);
        chk("t4_start", ks_start, 1);
        chk("t4_old_valid", bus.rk_valid_o, 2'b01);
        chk("t4_old_data", bus.rk_data_o, RK256_1);
        chk("t4_no_gnt", bus.gnt_o, 0);
        bus.req_i = 0;
        wait_rdy("t4_rdy", n);
        read(0, 4'd10, RKF_10, "t4");

        stuck = 1;
        load_key(KS_128, K128);
        bus.req_i = 2'b01;
        bus.req_idx_i = 8'h00;
        n = 0;
        while (!err && n < 50) begin
            tick();
            n++;
            if (n == 5) chk("t5_wait_gnt", bus.gnt_o, 0);
        end
        chk("t5_cyc", n, 33);
        chk("t5_err", err, 1);
        chk("t5_idle", bus.key_ready_o, 1);
        chk("t5_rdy", key_rdy, 0);
        bus.req_i = 0;
        stuck = 0;
        load_key(KS_128, K128);
        chk("t5_err_clr", err, 0);
        wait_rdy("t5_rdy2", n);
        read(0, 4'd11, '0, "t5_oor");
        chk("t5_oor_err", err, 1);

        load_key(KS_128, K128);
        tick();
        tick();
        #2 rst_n = 0;
        #1;
        chk("t6_async", {bus.key_ready_o, ks_start, key_rdy, nr, err, bus.rk_valid_o, bus.gnt_o}, '0);
        chk("t6_key", ks_key, '0);
        tick();
        rst_n = 1;
        tick();
        load_key(KS_128, K128);
        wait_rdy("t6_rdy", n);
        bus.req_i = 2'b01;
        bus.req_idx_i = 8'h0a;
        #1;
        chk("t6_gnt", bus.gnt_o, 2'b01);
        #1 rst_n = 0;
        tick();
        chk("t6_no_valid", bus.rk_valid_o, 0);
        chk("t6_data", bus.rk_data_o, '0);
        bus.req_i = 0;
        rst_n = 1;
        tick();
        load_key(KS_256, K256);
        wait_rdy("t6_reload", n);
        chk("t6_lat", n, 12);
        read(0, 4'd14, RK256_14, "t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
